// File: rtl/div_result_collector.sv
// div_result_collector: assembles divider step results into quotient/remainder and presents them on valid/ready.
//   params: W operand width and number of steps per division
//   in:  clk, rst (sync, active-high), start, start_dividend[W], start_dz,
//        step_valid, step_q, step_r[W], res_ready
//   out: res_valid, quotient[W], remainder[W], dz_err, busy
module div_result_collector #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] start_dividend,
   input  logic         start_dz,
   input  logic         step_valid,
   input  logic         step_q,
   input  logic [W-1:0] step_r,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         dz_err,
   output logic         busy
);
   localparam int CW = $clog2(W + 1);
   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic go, last;
   // a start in HOLD only counts when the pending result is taken in the same cycle
   always_comb begin
      go = start && (state != HOLD || res_ready);
      last = state == COLLECT && step_valid && cnt == CW'(W - 1);
      state_nx = go ? (start_dz ? HOLD : COLLECT) : last ? HOLD : (state == HOLD && res_ready) ? IDLE : state;
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk)
      if (rst) begin
         quotient <= '0;
         remainder <= '0;
         dz_err <= 1'b0;
         cnt <= '0;
      end else if (go) begin
         quotient <= start_dz ? '1 : '0;
         remainder <= start_dz ? start_dividend : '0;
         dz_err <= start_dz;
         cnt <= '0;
      end else if (state == COLLECT && step_valid) begin
         quotient <= {quotient[W-2:0], step_q};
         remainder <= step_r;
         cnt <= cnt + 1'b1;
      end
   assign res_valid = state == HOLD;
   assign busy = state == COLLECT;
endmodule

// File: tb/tb_div_result_collector.sv
// tb_div_result_collector: directed vectors with a queue scoreboard checked at each result transfer.
module tb_div_result_collector;
   localparam int W = 4;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, start_dz = 1'b0, step_valid = 1'b0, step_q = 1'b0, res_ready = 1'b0;
   logic [W-1:0] start_dividend = '0, step_r = '0;
   logic res_valid, dz_err, busy;
   logic [W-1:0] quotient, remainder;
   logic [2*W:0] sb[$];
   logic [2*W:0] exp_e;
   int passed = 0, total = 0;

   div_result_collector #(.W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .start_dividend(start_dividend), .start_dz(start_dz),
      .step_valid(step_valid), .step_q(step_q), .step_r(step_r), .res_valid(res_valid),
      .res_ready(res_ready), .quotient(quotient), .remainder(remainder), .dz_err(dz_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [W-1:0] d, input logic dz);
      start = 1'b1;
      start_dividend = d;
      start_dz = dz;
      tick();
      start = 1'b0;
      start_dz = 1'b0;
   endtask

   task automatic step(input logic q, input logic [W-1:0] r);
      step_valid = 1'b1;
      step_q = q;
      step_r = r;
      tick();
      step_valid = 1'b0;
   endtask

   task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
      sb.push_back({q, r, dz});
   endtask

   // monitor: inputs are stable between negedge and the next posedge, so this sees the transfer condition
   always @(negedge clk)
      if (!rst && res_valid && res_ready) begin
         if (sb.size() == 0) chk("unexpected_result", 1, 0);
         else begin
            exp_e = sb.pop_front();
            chk("sb_quotient", quotient, exp_e[2*W:W+1]);
            chk("sb_remainder", remainder, exp_e[W:1]);
            chk("sb_dz_err", dz_err, exp_e[0]);
         end
      end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      tick();
      tick();
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dz_err", dz_err, 0);
      rst = 1'b0;
      tick();

      // 14/3 full rate
      res_ready = 1'b1;
      push(4'd4, 4'd2, 1'b0);
      do_start(4'd14, 1'b0);
      chk("t1_busy", busy, 1);
      chk("t1_rv0", res_valid, 0);
      step(0, 4'd1);
      step(1, 4'd0);
      step(0, 4'd1);
      chk("t1_rv_early", res_valid, 0);
      step(0, 4'd2);
      chk("t1_rv", res_valid, 1);
      chk("t1_busy_done", busy, 0);
      tick();
      chk("t1_rv_drop", res_valid, 0);

      // divide-by-zero
      res_ready = 1'b0;
      push(4'd15, 4'd9, 1'b1);
      do_start(4'd9, 1'b1);
      chk("dz_rv", res_valid, 1);
      chk("dz_busy", busy, 0);
      chk("dz_q", quotient, 15);
      chk("dz_r", remainder, 9);
      chk("dz_err", dz_err, 1);
      res_ready = 1'b1;
      tick();
      chk("dz_rv_drop", res_valid, 0);
      chk("dz_busy_after", busy, 0);

      // backpressure and gaps
      res_ready = 1'b0;
      push(4'd4, 4'd2, 1'b0);
      do_start(4'd14, 1'b0);
      step(0, 4'd1);
      tick();
      step(1, 4'd0);
      tick();
      tick();
      chk("bp_busy_gap", busy, 1);
      step(0, 4'd1);
      chk("bp_rv_early", res_valid, 0);
      step(0, 4'd2);
      for (int i = 0; i < 5; i++) begin
         step(1, 4'd7);
         chk("bp_hold_rv", res_valid, 1);
         chk("bp_hold_q", quotient, 4);
         chk("bp_hold_r", remainder, 2);
      end
      res_ready = 1'b1;
      tick();
      chk("bp_rv_drop", res_valid, 0);

      // abort mid-COLLECT
      do_start(4'd14, 1'b0);
      step(0, 4'd1);
      step(1, 4'd0);
      push(4'd3, 4'd1, 1'b0);
      do_start(4'd7, 1'b0);
      chk("ab_q_cleared", quotient, 0);
      step(0, 4'd0);
      step(0, 4'd1);
      step(1, 4'd1);
      chk("ab_rv_early", res_valid, 0);
      step(1, 4'd1);
      chk("ab_rv", res_valid, 1);
      chk("ab_q", quotient, 3);
      chk("ab_r", remainder, 1);
      tick();
      chk("ab_rv_drop", res_valid, 0);

      // back-to-back; start dropped without res_ready, then accepted with it
      res_ready = 1'b0;
      push(4'd4, 4'd2, 1'b0);
      do_start(4'd14, 1'b0);
      step(0, 4'd1);
      step(1, 4'd0);
      step(0, 4'd1);
      step(0, 4'd2);
      do_start(4'd7, 1'b0);
      chk("bb_drop_rv", res_valid, 1);
      chk("bb_drop_q", quotient, 4);
      chk("bb_drop_busy", busy, 0);
      push(4'd3, 4'd1, 1'b0);
      res_ready = 1'b1;
      step_valid = 1'b1;
      step_q = 1'b1;
      step_r = 4'd5;
      do_start(4'd7, 1'b0);
      step_valid = 1'b0;
      chk("bb_busy", busy, 1);
      chk("bb_rv", res_valid, 0);
      chk("bb_q_cleared", quotient, 0);
      chk("bb_r_cleared", remainder, 0);
      step(0, 4'd0);
      step(0, 4'd1);
      step(1, 4'd1);
      step(1, 4'd1);
      chk("bb_rv2", res_valid, 1);
      tick();
      chk("bb_rv2_drop", res_valid, 0);

      // reset mid-COLLECT
      do_start(4'd14, 1'b0);
      step(0, 4'd1);
      step(1, 4'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_busy", busy, 0);
      chk("mr_rv", res_valid, 0);
      chk("mr_q", quotient, 0);
      chk("mr_r", remainder, 0);
      chk("mr_dz", dz_err, 0);
      step(1, 4'd1);
      step(1, 4'd1);
      step(1, 4'd1);
      chk("mr_ign_busy", busy, 0);
      chk("mr_ign_rv", res_valid, 0);
      chk("mr_ign_q", quotient, 0);
      chk("mr_ign_r", remainder, 0);

      tick();
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
